// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM controller: register map and PWM limits.
package led_pwm_pkg;

  // Word register indices on the data_m bus
  typedef enum logic [2:0] {
    REG_VALUE    = 3'd0,
    REG_SET      = 3'd1,
    REG_CLEAR    = 3'd2,
    REG_BLINK_EN = 3'd3,
    REG_CTRL     = 3'd4
  } reg_idx_e;

  // Duty value that forces the PWM output permanently on
  localparam logic [7:0] DUTY_FULL = 8'd255;

  // Last pwm_cnt value before wrapping; gives a 255-step frame
  localparam logic [7:0] PWM_MAX = 8'd254;

endpackage

// File: rtl/led_pwm_timebase.sv
// Timebase for the LED PWM controller: prescaler, PWM step counter,
// frame pulse and the blink divider that produces blink_phase.
module led_pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE = 196
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] blink_period,
  input  logic       blink_clr,
  output logic [7:0] pwm_cnt,
  output logic       frame,
  output logic       blink_phase
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_r;
  logic [7:0]    pwm_cnt_r;
  logic [7:0]    blink_cnt_r;
  logic          blink_phase_r;
  logic          step_s;
  logic          frame_s;
  logic [7:0]    blink_last_s;

  assign step_s       = (presc_r == PS_LAST);
  assign frame_s      = step_s && (pwm_cnt_r == PWM_MAX);
  assign blink_last_s = blink_period - 8'd1;

  // Prescaler: count 0..PRESCALE-1, step pulse on the last count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= '0;
    end else if (step_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // PWM step counter: 0..PWM_MAX, advanced once per step pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_r <= 8'd0;
    end else if (step_s) begin
      pwm_cnt_r <= (pwm_cnt_r == PWM_MAX) ? 8'd0 : pwm_cnt_r + 8'd1;
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

  // Blink divider: toggles phase every blink_period frames; period 0 holds steady-on
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_r   <= 8'd0;
      blink_phase_r <= 1'b1;
    end else if (blink_period == 8'd0) begin
      blink_cnt_r   <= 8'd0;
      blink_phase_r <= 1'b1;
    end else if (blink_clr) begin
      blink_cnt_r   <= 8'd0;
      blink_phase_r <= blink_phase_r;
    end else if (frame_s) begin
      if (blink_cnt_r == blink_last_s) begin
        blink_cnt_r   <= 8'd0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r   <= blink_cnt_r + 8'd1;
        blink_phase_r <= blink_phase_r;
      end
    end else begin
      blink_cnt_r   <= blink_cnt_r;
      blink_phase_r <= blink_phase_r;
    end
  end

  assign pwm_cnt     = pwm_cnt_r;
  assign frame       = frame_s;
  assign blink_phase = blink_phase_r;

endmodule

// File: rtl/led_pwm_ctrl.sv
// LED PWM controller: bus-programmable LED value/blink registers with a
// global PWM duty and blink period, driving registered LED outputs.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PRESCALE = 196
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NUM_LEDS-1:0] leds_out,
  input  logic                cs,
  input  logic [2:0]          data_m_addr,
  input  logic [15:0]         data_m_data_in,
  output logic [15:0]         data_m_data_out,
  input  logic                data_m_access,
  output logic                data_m_ack,
  input  logic                data_m_wr_en,
  input  logic [1:0]          data_m_bytesel
);

  // Bits that correspond to real LED channels; everything above stays 0
  localparam logic [15:0] LED_MASK = 16'((17'd1 << NUM_LEDS) - 17'd1);

  logic [15:0]         value_r;
  logic [15:0]         blink_en_r;
  logic [7:0]          duty_r;
  logic [7:0]          blink_period_r;
  logic [NUM_LEDS-1:0] leds_r;
  logic [15:0]         rdata_out_r;
  logic                ack_r;

  logic                sel_s;
  logic                wr_s;
  logic                rd_s;
  logic [15:0]         byte_mask_s;
  logic [15:0]         led_wmask_s;
  logic [15:0]         wbits_s;
  logic [15:0]         rdata_s;
  logic                blink_clr_s;
  logic                pwm_on_s;
  logic [7:0]          pwm_cnt_s;
  logic                frame_unused_s;
  logic                blink_phase_s;

  assign sel_s       = cs && data_m_access;
  assign wr_s        = sel_s && data_m_wr_en;
  assign rd_s        = sel_s && !data_m_wr_en;
  assign byte_mask_s = {{8{data_m_bytesel[1]}}, {8{data_m_bytesel[0]}}};
  assign led_wmask_s = byte_mask_s & LED_MASK;
  assign wbits_s     = data_m_data_in & led_wmask_s;

  // Blink divider restarts only when a CTRL write actually changes the period
  assign blink_clr_s = wr_s && (data_m_addr == REG_CTRL) && data_m_bytesel[1]
                       && (data_m_data_in[15:8] != blink_period_r);

  // frame is consumed inside the timebase; exposed here only for debug probing
  led_pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .reset        (reset),
    .blink_period (blink_period_r),
    .blink_clr    (blink_clr_s),
    .pwm_cnt      (pwm_cnt_s),
    .frame        (frame_unused_s),
    .blink_phase  (blink_phase_s)
  );

  // PWM comparator with full-duty override
  always_comb begin
    pwm_on_s = 1'b0;
    if (duty_r == DUTY_FULL) begin
      pwm_on_s = 1'b1;
    end else begin
      pwm_on_s = (pwm_cnt_s < duty_r);
    end
  end

  // Register read mux; unmapped indices read 0
  always_comb begin
    rdata_s = 16'h0000;
    case (reg_idx_e'(data_m_addr))
      REG_VALUE:    rdata_s = value_r & LED_MASK;
      REG_BLINK_EN: rdata_s = blink_en_r & LED_MASK;
      REG_CTRL:     rdata_s = {blink_period_r, duty_r};
      default:      rdata_s = 16'h0000;
    endcase
  end

  // Register writes with per-byte enables; SET/CLEAR modify VALUE in place
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_r        <= 16'h0000;
      blink_en_r     <= 16'h0000;
      duty_r         <= DUTY_FULL;
      blink_period_r <= 8'd0;
    end else if (wr_s) begin
      case (reg_idx_e'(data_m_addr))
        REG_VALUE:    value_r    <= (value_r & ~led_wmask_s) | wbits_s;
        REG_SET:      value_r    <= value_r | wbits_s;
        REG_CLEAR:    value_r    <= value_r & ~wbits_s;
        REG_BLINK_EN: blink_en_r <= (blink_en_r & ~led_wmask_s) | wbits_s;
        REG_CTRL: begin
          if (data_m_bytesel[0]) begin
            duty_r <= data_m_data_in[7:0];
          end else begin
            duty_r <= duty_r;
          end
          if (data_m_bytesel[1]) begin
            blink_period_r <= data_m_data_in[15:8];
          end else begin
            blink_period_r <= blink_period_r;
          end
        end
        default: begin
          value_r <= value_r;
        end
      endcase
    end else begin
      value_r <= value_r;
    end
  end

  // Bus response: ack one cycle after every selected access, data only for reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_r       <= 1'b0;
      rdata_out_r <= 16'h0000;
    end else begin
      ack_r       <= sel_s;
      rdata_out_r <= rd_s ? rdata_s : 16'h0000;
    end
  end

  // Registered LED drive: value gated by PWM and, for blinking channels, blink phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_r <= '0;
    end else begin
      leds_r <= value_r[NUM_LEDS-1:0]
                & {NUM_LEDS{pwm_on_s}}
                & (~blink_en_r[NUM_LEDS-1:0] | {NUM_LEDS{blink_phase_s}});
    end
  end

  assign leds_out        = leds_r;
  assign data_m_ack      = ack_r;
  assign data_m_data_out = rdata_out_r;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed self-checking bench for led_pwm_ctrl (NUM_LEDS=12, PRESCALE=2).
module tb_led_pwm_ctrl;

  logic        clk;
  logic        reset;
  logic [11:0] leds_out;
  logic        cs;
  logic [2:0]  data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_ack;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;

  int total;
  int bad;

  led_pwm_ctrl #(
    .NUM_LEDS (12),
    .PRESCALE (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .leds_out        (leds_out),
    .cs              (cs),
    .data_m_addr     (data_m_addr),
    .data_m_data_in  (data_m_data_in),
    .data_m_data_out (data_m_data_out),
    .data_m_access   (data_m_access),
    .data_m_ack      (data_m_ack),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_bytesel  (data_m_bytesel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus access: present at a negedge, sample ack/data at the next negedge
  task automatic bus(input logic wr, input logic [2:0] addr, input logic [15:0] wdata,
                     input logic [1:0] bsel, output logic ack, output logic [15:0] rdata);
    @(negedge clk);
    cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = wr;
    data_m_addr = addr; data_m_data_in = wdata; data_m_bytesel = bsel;
    @(negedge clk);
    cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
    data_m_data_in = 16'h0000; data_m_bytesel = 2'b00;
    ack = data_m_ack;
    rdata = data_m_data_out;
  endtask

  initial begin
    logic        a;
    logic [15:0] d;
    int          n;
    int          hi;
    int          led1_off;
    logic        prev;

    total = 0; bad = 0;
    cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
    data_m_addr = 3'd0; data_m_data_in = 16'h0000; data_m_bytesel = 2'b00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_leds", 32'(leds_out), 32'h0);
    chk("rst_ack", 32'(data_m_ack), 32'h0);
    chk("rst_dout", 32'(data_m_data_out), 32'h0);
    reset = 1'b0;

    // Reset values through the bus
    bus(1'b0, 3'd0, 16'h0000, 2'b11, a, d);
    chk("rd_value_ack", 32'(a), 32'h1);
    chk("rd_value_data", 32'(d), 32'h0000);
    @(negedge clk);
    chk("ack_one_cycle", 32'(data_m_ack), 32'h0);
    bus(1'b0, 3'd4, 16'h0000, 2'b11, a, d);
    chk("rd_ctrl_rst", 32'(d), 32'h00FF);

    // Byte enables and LED-width masking
    bus(1'b1, 3'd0, 16'hFFFF, 2'b01, a, d);
    chk("wr_ack", 32'(a), 32'h1);
    chk("wr_dout_zero", 32'(d), 32'h0000);
    bus(1'b0, 3'd0, 16'h0000, 2'b11, a, d);
    chk("value_lo_byte", 32'(d), 32'h00FF);
    bus(1'b1, 3'd0, 16'hFFFF, 2'b10, a, d);
    bus(1'b0, 3'd0, 16'h0000, 2'b11, a, d);
    chk("value_hi_byte", 32'(d), 32'h0FFF);
    bus(1'b1, 3'd3, 16'hFFFF, 2'b11, a, d);
    bus(1'b0, 3'd3, 16'h0000, 2'b11, a, d);
    chk("blink_en_mask", 32'(d), 32'h0FFF);
    bus(1'b1, 3'd3, 16'h0000, 2'b11, a, d);
    bus(1'b1, 3'd5, 16'hFFFF, 2'b11, a, d);
    bus(1'b0, 3'd5, 16'h0000, 2'b11, a, d);
    chk("unmapped_ack", 32'(a), 32'h1);
    chk("unmapped_rd", 32'(d), 32'h0000);

    // SET / CLEAR
    bus(1'b1, 3'd0, 16'h00F0, 2'b11, a, d);
    bus(1'b1, 3'd1, 16'h0003, 2'b11, a, d);
    bus(1'b1, 3'd2, 16'h0010, 2'b11, a, d);
    bus(1'b0, 3'd0, 16'h0000, 2'b11, a, d);
    chk("set_clear_value", 32'(d), 32'h00E3);
    bus(1'b0, 3'd1, 16'h0000, 2'b11, a, d);
    chk("set_reads_0", 32'(d), 32'h0000);
    bus(1'b0, 3'd2, 16'h0000, 2'b11, a, d);
    chk("clear_reads_0", 32'(d), 32'h0000);

    // PWM duty: count led0 high over one full 510-clock PWM period
    bus(1'b1, 3'd0, 16'h0001, 2'b11, a, d);
    bus(1'b1, 3'd4, 16'h0040, 2'b11, a, d);
    repeat (4) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 510; i++) begin
      @(negedge clk);
      if (leds_out[0]) hi++;
    end
    chk("duty64_high", 32'(hi), 32'd128);
    bus(1'b1, 3'd4, 16'h0000, 2'b11, a, d);
    repeat (4) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 510; i++) begin
      @(negedge clk);
      if (leds_out[0]) hi++;
    end
    chk("duty0_high", 32'(hi), 32'd0);
    bus(1'b1, 3'd4, 16'h00FF, 2'b11, a, d);
    repeat (4) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 510; i++) begin
      @(negedge clk);
      if (leds_out[0]) hi++;
    end
    chk("duty255_high", 32'(hi), 32'd510);

    // Blink: period 2 frames on led0, led1 steady
    bus(1'b1, 3'd4, 16'h02FF, 2'b11, a, d);
    bus(1'b1, 3'd0, 16'h0003, 2'b11, a, d);
    bus(1'b1, 3'd3, 16'h0001, 2'b11, a, d);
    repeat (4) @(negedge clk);
    prev = leds_out[0];
    n = 0;
    while (leds_out[0] == prev && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("blink_first_toggle", 32'(n < 3000), 32'h1);
    prev = leds_out[0];
    n = 0;
    led1_off = 0;
    while (leds_out[0] == prev && n < 3000) begin
      @(negedge clk);
      n++;
      if (!leds_out[1]) led1_off++;
    end
    chk("blink_interval", 32'(n), 32'd1020);
    chk("led1_steady", 32'(led1_off), 32'd0);

    // Reset mid-blink and mid-access
    repeat (300) @(negedge clk);
    chk("pre_reset_led1", 32'(leds_out[1]), 32'h1);
    cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0; data_m_addr = 3'd4;
    #2 reset = 1'b1;
    #1;
    chk("reset_leds_now", 32'(leds_out), 32'h0);
    chk("reset_dout_now", 32'(data_m_data_out), 32'h0);
    @(negedge clk);
    cs = 1'b0; data_m_access = 1'b0;
    chk("reset_no_ack", 32'(data_m_ack), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_no_ack", 32'(data_m_ack), 32'h0);
    bus(1'b0, 3'd4, 16'h0000, 2'b11, a, d);
    chk("post_reset_ctrl", 32'(d), 32'h00FF);

    // blink_phase back to 1: a blinking channel with period 0 stays lit
    bus(1'b1, 3'd0, 16'h0001, 2'b11, a, d);
    bus(1'b1, 3'd3, 16'h0001, 2'b11, a, d);
    repeat (3) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (leds_out[0]) hi++;
    end
    chk("phase_after_reset", 32'(hi), 32'd1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
